instr_fetch_unit: RTL

- Program store and prefetch stage that sits directly upstream of simple4_proc's control FSM.
- Holds up to 16 11-bit instructions, loaded through a write port while idle.
- After start, fetches sequentially from PC 0 and delivers decoded fields through a valid/ready handshake.
- A 2-entry prefetch buffer absorbs FSM stalls. Fetch stops at a HALT opcode.

---
 rtl/proc4_pkg.sv | 47 ++++
 rtl/fetch_buf2.sv | 87 ++++++++
 rtl/instr_fetch_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/proc4_pkg.sv
// ---------------------------------------------------------------------------
// proc4_pkg
// Shared definitions for the simple4_proc front end.
//   - Instruction geometry: 11-bit word, [10:8] opcode, [7:4] addr, [3:0] data.
//   - Opcode constants understood by the downstream control FSM.
//   - Fetch state enum and the prefetch buffer entry layout.
// No ports (package).
// ---------------------------------------------------------------------------
package proc4_pkg;

    localparam int INSTR_W   = 11;
    localparam int PC_W      = 4;
    localparam int DEPTH     = 16;
    localparam int BUF_DEPTH = 2;

    localparam int OPC_MSB  = 10;
    localparam int OPC_LSB  = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 4;
    localparam int DATA_MSB = 3;
    localparam int DATA_LSB = 0;

    localparam logic [2:0] OP_STO  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    // One prefetch buffer slot: the fetch address travels with its word
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } buf_entry_t;

    // True when the word terminates the program
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_buf2.sv
// ---------------------------------------------------------------------------
// fetch_buf2
// Two-entry FIFO carrying {pc, instr} between the program memory read port
// and the consumer handshake. Slot 0 is always the head, so the head fields
// come straight from a register and stay stable while not popped.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             discard all entries this cycle (wins over push/pop)
//   push, push_pc,    write a new entry at the tail
//   push_instr
//   pop               remove the head (ignored when empty)
//   head_valid        buffer holds at least one entry
//   head_pc,          head entry fields
//   head_instr
//   count             number of entries held (0..2)
// ---------------------------------------------------------------------------
module fetch_buf2
    import proc4_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    output logic               head_valid,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [1:0]         count
);

    buf_entry_t slot0_q, slot0_d;
    buf_entry_t slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic [1:0] after_pop;
    buf_entry_t new_entry;

    // Pop is applied first so that a push into a full buffer lands in the
    // slot that the same-cycle pop just freed.
    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        count_d   = count_q;
        after_pop = count_q;
        new_entry = '{pc: push_pc, instr: push_instr};

        if (pop && (count_q != 2'd0)) begin
            slot0_d   = slot1_q;
            after_pop = count_q - 2'd1;
        end

        if (push) begin
            if (after_pop == 2'd0) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
            count_d = after_pop + 2'd1;
        end else begin
            count_d = after_pop;
        end

        if (flush) begin
            count_d = 2'd0;
        end
    end

    // Storage is cleared on reset so the head fields read as zero afterwards
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_valid = (count_q != 2'd0);
    assign head_pc    = slot0_q.pc;
    assign head_instr = slot0_q.instr;
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Program store plus prefetch stage feeding the simple4_proc control FSM.
// A 16-word program is written while idle; start fetches sequentially from
// PC 0 through a synchronous read port into a 2-entry buffer, and the head
// is offered on a valid/ready handshake. A HALT word stops fetching, is
// dropped, and the unit reports halted once the buffer has drained.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   load_we/load_addr/load_data program write port (IDLE/HALTED only)
//   start                      begin execution at PC 0 (IDLE/HALTED only)
//   instr_valid/instr_ready    head handshake
//   instr_opcode/addr/data     decoded head fields
//   instr_pc                   fetch address of the head
//   busy                       running or draining
//   halted                     HALT reached and buffer empty
//   redirect_valid/redirect_pc flush and restart fetch at redirect_pc
//                              (present only with IFETCH_REDIRECT_EN)
// Optional feature macro: IFETCH_REDIRECT_EN
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import proc4_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_we,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
`ifdef IFETCH_REDIRECT_EN
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
`endif
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [2:0]         instr_opcode,
    output logic [3:0]         instr_addr,
    output logic [3:0]         instr_data,
    output logic [PC_W-1:0]    instr_pc,
    output logic               busy,
    output logic               halted
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] rd_data_q;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            in_flight_q, in_flight_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;

    logic               loadable;
    logic               mem_we;
    logic               ret_halt;
    logic               push;
    logic               pop;
    logic               issue;
    logic [1:0]         occupancy;
    logic               redirect;
    logic [PC_W-1:0]    redirect_target;
    logic               buf_valid;
    logic [PC_W-1:0]    buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic [1:0]         buf_count;

`ifdef IFETCH_REDIRECT_EN
    assign redirect        = redirect_valid && ((state_q == RUN) || (state_q == DRAIN));
    assign redirect_target = redirect_pc;
`else
    assign redirect        = 1'b0;
    assign redirect_target = '0;
`endif

    // Next-state logic. The issue gate counts the slot freed by a same-cycle
    // pop; without that, a steady ready=1 stream would stall every other
    // cycle. The invariant entries + in_flight <= 2 still holds because the
    // popped slot is gone at the same edge the new read is issued.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        in_flight_d = in_flight_q;
        issue       = 1'b0;

        loadable  = (state_q == IDLE) || (state_q == HALTED);
        mem_we    = loadable && load_we;
        ret_halt  = in_flight_q && is_halt(rd_data_q);
        pop       = buf_valid && instr_ready && !redirect;
        push      = in_flight_q && !ret_halt && !redirect;
        occupancy = buf_count + {1'b0, in_flight_q} - {1'b0, pop};

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d     = RUN;
                    pc_d        = '0;
                    in_flight_d = 1'b0;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d        = redirect_target;
                    in_flight_d = 1'b0;
                end else if (ret_halt) begin
                    state_d     = DRAIN;
                    in_flight_d = 1'b0;
                end else begin
                    issue       = (occupancy < 2'(BUF_DEPTH));
                    in_flight_d = issue;
                    pc_d        = pc_q + {{(PC_W-1){1'b0}}, issue};
                end
            end
            DRAIN: begin
                if (redirect) begin
                    state_d     = RUN;
                    pc_d        = redirect_target;
                    in_flight_d = 1'b0;
                end else if (buf_count == 2'd0) begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d == RUN) || (state_d == DRAIN);
        halted_d = (state_d == HALTED);
    end

    // Control state and the registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            in_flight_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            in_flight_q <= in_flight_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    // Program memory with a registered read port. Contents survive reset;
    // rd_data_q needs no reset because in_flight_q qualifies it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
        if (issue) begin
            rd_data_q <= mem[pc_q];
        end
    end

    fetch_buf2 u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_pc    (pc_q - {{(PC_W-1){1'b0}}, 1'b1}),
        .push_instr (rd_data_q),
        .pop        (pop),
        .head_valid (buf_valid),
        .head_pc    (buf_pc),
        .head_instr (buf_instr),
        .count      (buf_count)
    );

    assign instr_valid  = buf_valid;
    assign instr_opcode = buf_instr[OPC_MSB:OPC_LSB];
    assign instr_addr   = buf_instr[ADDR_MSB:ADDR_LSB];
    assign instr_data   = buf_instr[DATA_MSB:DATA_LSB];
    assign instr_pc     = buf_pc;
    assign busy         = busy_q;
    assign halted       = halted_q;

endmodule
